// File: rtl/seq_mux_n.sv
// rtl/seq_mux_n.sv - registered N:1 channel selector with latched select, range check and auto-scan
module seq_mux_n #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] d,
    input  logic [SW-1:0]  sel,
    input  logic           sel_load,
    input  logic           scan_en,
    output logic [W-1:0]   y,
    output logic           y_valid,
    output logic [SW-1:0]  cur_sel,
    output logic           sel_err
);

    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SW-1:0]   SEL_LAST   = SW'(N - 1);

    logic [W-1:0]  y_q,       y_d;
    logic          y_valid_q, y_valid_d;
    logic [SW-1:0] cur_sel_q, cur_sel_d;
    logic [DW-1:0] dwell_q,   dwell_d;
    logic          sel_err_q, sel_err_d;
    logic          sel_ok;

    // Selects wider than the channel count can name channels that do not exist.
    assign sel_ok = (int'(sel) < N);

    always_comb begin
        y_d = d[W-1:0];
        for (int i = 0; i < N; i++) begin
            if (cur_sel_q == SW'(i)) begin
                y_d = d[i*W +: W];
            end
        end
    end

    always_comb begin
        cur_sel_d = cur_sel_q;
        dwell_d   = '0;
        if (sel_load && sel_ok) begin
            cur_sel_d = sel;
        end else if (scan_en) begin
            if (dwell_q == DWELL_LAST) begin
                cur_sel_d = (cur_sel_q == SEL_LAST) ? '0 : cur_sel_q + 1'b1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
        sel_err_d = sel_load && !sel_ok;
        y_valid_d = (cur_sel_d == cur_sel_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            cur_sel_q <= '0;
            dwell_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cur_sel_q <= cur_sel_d;
            dwell_q   <= dwell_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_sel = cur_sel_q;
    assign sel_err = sel_err_q;

endmodule
